// File: rtl/sc_regfrogpoint.sv
// Frog position register bank: row index plus one-hot column, flattened matrix output,
// and a small PLAY/GOAL/RESPAWN machine that scores a point when the frog reaches the top row.
module sc_regfrogpoint #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int START_COL = 3,
  parameter int GOAL_HOLD = 25000000
) (
  input  logic                 SC_REGFROGPOINT_CLOCK_50,
  input  logic                 SC_REGFROGPOINT_RESET_InHigh,
  input  logic                 SC_REGFROGPOINT_load0_InLow,
  input  logic                 SC_REGFROGPOINT_load1_InLow,
  input  logic [1:0]           SC_REGFROGPOINT_shiftselection_In,
  input  logic                 SC_REGFROGPOINT_kill_InLow,
  output logic [ROWS*COLS-1:0] SC_REGFROGPOINT_matrix_Out,
  output logic                 SC_REGFROGPOINT_firstreg_OutLow,
  output logic                 SC_REGFROGPOINT_goal_OutHigh,
  output logic [3:0]           SC_REGFROGPOINT_score_Out
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(GOAL_HOLD + 1);

  localparam logic [COLS-1:0] START_ONEHOT = COLS'(1) << START_COL;
  localparam logic [RW-1:0]   ROW_ONE      = RW'(1);
  localparam logic [RW-1:0]   ROW_TOP      = RW'(ROWS - 1);
  localparam logic [RW-1:0]   ROW_PRE_TOP  = RW'(ROWS - 2);
  localparam logic [CW-1:0]   CNT_ONE      = CW'(1);
  localparam logic [CW-1:0]   HOLD_LAST    = CW'(GOAL_HOLD - 1);

  typedef enum logic [1:0] {
    S_PLAY    = 2'b00,
    S_GOAL    = 2'b01,
    S_RESPAWN = 2'b10
  } state_t;

  state_t          r_state;
  logic [RW-1:0]   r_row;
  logic [COLS-1:0] r_col;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_score;
  logic            r_goal;
  logic [ROWS*COLS-1:0] w_matrix;

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge SC_REGFROGPOINT_CLOCK_50) begin
    if (SC_REGFROGPOINT_RESET_InHigh) begin
      r_state <= S_PLAY;
      r_row   <= '0;
      r_col   <= START_ONEHOT;
      r_cnt   <= '0;
      r_score <= '0;
      r_goal  <= 1'b0;
    end else begin
      r_goal <= 1'b0;
      case (r_state)
        S_PLAY: begin
          // At most one action per cycle: kill, then up, then down, then shift.
          if (!SC_REGFROGPOINT_kill_InLow) begin
            r_row <= '0;
            r_col <= START_ONEHOT;
          end else if (!SC_REGFROGPOINT_load1_InLow) begin
            if (r_row != ROW_TOP) begin
              r_row <= r_row + ROW_ONE;
              if (r_row == ROW_PRE_TOP) begin
                r_state <= S_GOAL;
                r_goal  <= 1'b1;
                r_score <= r_score + 4'd1;
                r_cnt   <= '0;
              end
            end
          end else if (!SC_REGFROGPOINT_load0_InLow) begin
            if (r_row != '0) r_row <= r_row - ROW_ONE;
          end else begin
            case (SC_REGFROGPOINT_shiftselection_In)
              2'b01:   if (!r_col[COLS-1]) r_col <= r_col << 1;
              2'b10:   if (!r_col[0])      r_col <= r_col >> 1;
              default: ;
            endcase
          end
        end
        S_GOAL: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == HOLD_LAST) r_state <= S_RESPAWN;
        end
        S_RESPAWN: begin
          r_row   <= '0;
          r_col   <= START_ONEHOT;
          r_cnt   <= '0;
          r_state <= S_PLAY;
        end
        default: r_state <= S_RESPAWN;
      endcase
    end
  end

  // NOTE: the matrix gets a full default before the loop so no bit can infer a latch.
  always_comb begin
    w_matrix = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (r_row == RW'(i)) w_matrix[i*COLS +: COLS] = r_col;
    end
  end

  assign SC_REGFROGPOINT_matrix_Out      = w_matrix;
  assign SC_REGFROGPOINT_firstreg_OutLow = (r_row != '0);
  assign SC_REGFROGPOINT_goal_OutHigh    = r_goal;
  assign SC_REGFROGPOINT_score_Out       = r_score;

endmodule

// File: tb/tb_sc_regfrogpoint.sv
// Directed bench for sc_regfrogpoint with an 8x8 matrix and a 4-cycle goal hold.
module tb_sc_regfrogpoint;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int START_COL = 3;
  localparam int GOAL_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load0_n, load1_n, kill_n;
  logic [1:0]  shift;
  logic [63:0] matrix;
  logic        firstreg_n, goal;
  logic [3:0]  score;

  int n_checks = 0;
  int n_errors = 0;

  sc_regfrogpoint #(
    .ROWS(ROWS), .COLS(COLS), .START_COL(START_COL), .GOAL_HOLD(GOAL_HOLD)
  ) dut (
    .SC_REGFROGPOINT_CLOCK_50          (clk),
    .SC_REGFROGPOINT_RESET_InHigh      (rst),
    .SC_REGFROGPOINT_load0_InLow       (load0_n),
    .SC_REGFROGPOINT_load1_InLow       (load1_n),
    .SC_REGFROGPOINT_shiftselection_In (shift),
    .SC_REGFROGPOINT_kill_InLow        (kill_n),
    .SC_REGFROGPOINT_matrix_Out        (matrix),
    .SC_REGFROGPOINT_firstreg_OutLow   (firstreg_n),
    .SC_REGFROGPOINT_goal_OutHigh      (goal),
    .SC_REGFROGPOINT_score_Out         (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pos(input int r, input int c);
    logic [63:0] m;
    m = '0;
    m[r*COLS + c] = 1'b1;
    return m;
  endfunction

  // One clock: outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load0_n = 1'b1; load1_n = 1'b1; kill_n = 1'b1; shift = 2'b11;
  endtask

  // Climb from row 0 to the goal, then wait out the hold and the respawn cycle.
  task automatic do_goal();
    load1_n = 1'b0;
    repeat (ROWS - 1) step();
    idle();
    repeat (GOAL_HOLD + 1) step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    check("rst_matrix", matrix, 64'h08);
    check("rst_first", {63'd0, firstreg_n}, 64'd0);
    check("rst_goal", {63'd0, goal}, 64'd0);
    rst = 1'b0;
    repeat (10) step();
    check("idle_matrix", matrix, 64'h08);
    check("idle_first", {63'd0, firstreg_n}, 64'd0);
    check("idle_score", {60'd0, score}, 64'd0);
    shift = 2'b00;
    step();
    check("hold00", matrix, pos(0, 3));

    // Up, down, and down again at the bottom edge.
    idle(); load1_n = 1'b0; step();
    check("up_matrix", matrix, pos(1, 3));
    check("up_first", {63'd0, firstreg_n}, 64'd1);
    idle(); load0_n = 1'b0; step();
    check("down_matrix", matrix, pos(0, 3));
    step();
    check("down_floor", matrix, pos(0, 3));
    check("down_first", {63'd0, firstreg_n}, 64'd0);

    // Column shifts saturate at both edges.
    idle(); shift = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("shl_%0d", k), matrix, pos(0, (3 + k > 7) ? 7 : 3 + k));
    end
    shift = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("shr_%0d", k), matrix, pos(0, (7 - k < 0) ? 0 : 7 - k));
    end
    idle(); kill_n = 1'b0; step();
    check("kill_row0", matrix, pos(0, 3));

    // First goal: pulse, score, ignored inputs during hold, then respawn.
    idle(); load1_n = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("climb_%0d", k), matrix, pos(k, 3));
      check($sformatf("climb_goal_%0d", k), {63'd0, goal}, (k == 7) ? 64'd1 : 64'd0);
    end
    check("goal_score", {60'd0, score}, 64'd1);
    idle(); kill_n = 1'b0; load0_n = 1'b0; shift = 2'b01;
    for (int k = 1; k <= GOAL_HOLD; k++) begin
      step();
      check($sformatf("hold_%0d", k), matrix, pos(7, 3));
      check($sformatf("hold_goal_%0d", k), {63'd0, goal}, 64'd0);
    end
    idle();
    step();
    check("respawn", matrix, pos(0, 3));
    check("respawn_score", {60'd0, score}, 64'd1);

    // Kill beats load1 on the same cycle.
    load1_n = 1'b0;
    repeat (4) step();
    check("row4", matrix, pos(4, 3));
    kill_n = 1'b0; step();
    check("kill_wins", matrix, pos(0, 3));
    check("kill_score", {60'd0, score}, 64'd1);
    idle();

    // Score wraps after 16 goals.
    repeat (14) do_goal();
    check("score15", {60'd0, score}, 64'd15);
    check("score15_pos", matrix, pos(0, 3));
    do_goal();
    check("score_wrap", {60'd0, score}, 64'd0);

    // Reset in the middle of the goal hold.
    load1_n = 1'b0;
    repeat (ROWS - 1) step();
    idle();
    step();
    check("pre_rst_goal", matrix, pos(7, 3));
    check("pre_rst_score", {60'd0, score}, 64'd1);
    rst = 1'b1;
    step();
    check("mid_rst_matrix", matrix, 64'h08);
    check("mid_rst_first", {63'd0, firstreg_n}, 64'd0);
    check("mid_rst_score", {60'd0, score}, 64'd0);
    check("mid_rst_goal", {63'd0, goal}, 64'd0);
    rst = 1'b0;
    load1_n = 1'b0; step();
    check("post_rst_play", matrix, pos(1, 3));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
